// File: rtl/rggen_rtl_pkg.sv
// +----------------------------------------------------------------------------+
// | rggen_rtl_pkg: shared register-bus types and helpers                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'd0,
    RGGEN_EXOKAY       = 2'd1,
    RGGEN_SLAVE_ERROR  = 2'd2,
    RGGEN_DECODE_ERROR = 2'd3
  } rggen_status;

  // The upper status bit separates the two error responses from the two OK ones.
  function automatic logic rggen_is_error(input rggen_status status);
    return status[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rggen_access_timer.sv
// +----------------------------------------------------------------------------+
// | rggen_access_timer: wait-cycle counter for a stalled register access      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rggen_access_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int COUNT_WIDTH = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [COUNT_WIDTH-1:0] count_d;
  logic [COUNT_WIDTH-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_count) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the LIMIT-th stalled cycle, i.e. when the count is about to reach LIMIT.
  assign o_expired = (count_q == COUNT_WIDTH'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/rggen_apb_host_adapter.sv
// +----------------------------------------------------------------------------+
// | rggen_apb_host_adapter: APB completer to rggen register-bus bridge         |
// | Optional wait-cycle timeout when RGGEN_APB_TIMEOUT_EN is defined.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rggen_apb_host_adapter
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_psel,
  input  logic                     i_penable,
  input  logic                     i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0] i_paddr,
  input  logic [BUS_WIDTH-1:0]     i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
  output logic                     o_pready,
  output logic                     o_pslverr,
  output logic [BUS_WIDTH-1:0]     o_prdata,
  output logic                     o_reg_valid,
  output logic                     o_reg_write,
  output logic [ADDRESS_WIDTH-1:0] o_reg_address,
  output logic [BUS_WIDTH-1:0]     o_reg_write_data,
  output logic [BUS_WIDTH-1:0]     o_reg_write_mask,
  input  logic                     i_reg_ready,
  input  logic [BUS_WIDTH-1:0]     i_reg_read_data,
  input  logic [1:0]               i_reg_status
);

  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                   state_d,   state_q;
  logic                     valid_d,   valid_q;
  logic                     write_d,   write_q;
  logic [ADDRESS_WIDTH-1:0] address_d, address_q;
  logic [BUS_WIDTH-1:0]     wdata_d,   wdata_q;
  logic [BUS_WIDTH-1:0]     mask_d,    mask_q;
  logic                     pready_d,  pready_q;
  logic                     pslverr_d, pslverr_q;
  logic [BUS_WIDTH-1:0]     prdata_d,  prdata_q;

  logic [BUS_WIDTH-1:0]     strb_mask;
  logic                     setup_seen;
  logic                     timeout_expired;
  rggen_status              status;

  assign status     = rggen_status'(i_reg_status);
  assign setup_seen = (state_q == ST_IDLE) && i_psel && !i_penable;

  for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_strb
    assign strb_mask[8*i +: 8] = {8{i_pstrb[i]}};
  end

`ifdef RGGEN_APB_TIMEOUT_EN
  rggen_access_timer #(
    .LIMIT     (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (setup_seen),
    .i_count   ((state_q == ST_BUSY) && !i_reg_ready),
    .o_expired (timeout_expired)
  );
`else
  logic timeout_unused;
  assign timeout_unused  = (TIMEOUT_CYCLES != 0);
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    write_d   = write_q;
    address_d = address_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    // Response outputs are single-cycle pulses; only the BUSY exit raises them.
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (setup_seen) begin
          state_d   = ST_BUSY;
          valid_d   = 1'b1;
          write_d   = i_pwrite;
          address_d = i_paddr;
          wdata_d   = i_pwdata;
          mask_d    = i_pwrite ? strb_mask : '1;
        end
      end
      ST_BUSY: begin
        // Ready wins over a simultaneous timeout so a late target still completes.
        if (valid_q && i_reg_ready) begin
          state_d   = ST_DONE;
          valid_d   = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = rggen_is_error(status);
          prdata_d  = write_q ? '0 : i_reg_read_data;
        end else if (timeout_expired) begin
          state_d   = ST_DONE;
          valid_d   = 1'b0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      address_q <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      address_q <= address_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  assign o_reg_valid      = valid_q;
  assign o_reg_write      = write_q;
  assign o_reg_address    = address_q;
  assign o_reg_write_data = wdata_q;
  assign o_reg_write_mask = mask_q;
  assign o_pready         = pready_q;
  assign o_pslverr        = pslverr_q;
  assign o_prdata         = prdata_q;

endmodule

`default_nettype wire
